// File: rtl/freq_divider_ctrl.sv
// Run/stop and divide-ratio controller: owns the divide counter, arbitrates two
// ratio requesters round-robin, and applies new codes only at output-period ends.
module freq_divider_ctrl #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DIV_W = 3
) (
  input  logic             inClk,
  input  logic             reset,
  input  logic             run,
  input  logic             reqA,
  input  logic [DIV_W-1:0] divA,
  output logic             ackA,
  input  logic             reqB,
  input  logic [DIV_W-1:0] divB,
  output logic             ackB,
  output logic             outClk,
  output logic             outPulse,
  output logic [DIV_W-1:0] curDiv,
  output logic             busy,
  output logic             switchDone
);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0]   r_cur_div, w_cur_div_nxt;
  logic [DIV_W-1:0]   r_pend_div, w_pend_div_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_rr_ptr, w_rr_ptr_nxt;
  logic               r_out_clk, w_out_clk_nxt;
  logic               r_out_pulse, w_out_pulse_nxt;
  logic               r_switch_done, w_switch_done_nxt;
  logic               w_ack_a, w_ack_b;
  logic [CNT_W-1:0]   w_mask;
  logic               w_term;

  // Low curDiv+1 bits of the counter all ones marks the last cycle of a period.
  assign w_mask = CNT_W'((32'd1 << (32'(r_cur_div) + 32'd1)) - 32'd1);
  assign w_term = ((r_cnt & w_mask) == w_mask);

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_cur_div_nxt     = r_cur_div;
    w_pend_div_nxt    = r_pend_div;
    w_busy_nxt        = r_busy;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_out_pulse_nxt   = 1'b0;
    w_switch_done_nxt = 1'b0;
    w_ack_a           = 1'b0;
    w_ack_b           = 1'b0;

    case (r_state)
      ST_STOP: begin
        w_cnt_nxt = '0;
        if (r_busy) begin
          w_cur_div_nxt     = r_pend_div;
          w_busy_nxt        = 1'b0;
          w_switch_done_nxt = 1'b1;
        end
        if (run) begin
          w_state_nxt     = ST_RUN;
          w_out_pulse_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_term) begin
          if (r_busy) begin
            w_cnt_nxt         = '0;
            w_cur_div_nxt     = r_pend_div;
            w_busy_nxt        = 1'b0;
            w_switch_done_nxt = 1'b1;
          end
          if (!run) begin
            w_state_nxt = ST_STOP;
            w_cnt_nxt   = '0;
          end else begin
            w_out_pulse_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_STOP;
    endcase

    // Capture is disjoint from apply: it needs busy low, apply needs busy high.
    if (!reset && !r_busy) begin
      if (reqA && (!reqB || r_rr_ptr == RR_A)) begin
        w_ack_a        = 1'b1;
        w_pend_div_nxt = divA;
        w_busy_nxt     = 1'b1;
        w_rr_ptr_nxt   = RR_B;
      end else if (reqB) begin
        w_ack_b        = 1'b1;
        w_pend_div_nxt = divB;
        w_busy_nxt     = 1'b1;
        w_rr_ptr_nxt   = RR_A;
      end
    end

    w_out_clk_nxt = w_cnt_nxt[w_cur_div_nxt];
  end

  always_ff @(posedge inClk) begin
    if (reset) begin
      r_state       <= ST_STOP;
      r_cnt         <= '0;
      r_cur_div     <= '0;
      r_pend_div    <= '0;
      r_busy        <= 1'b0;
      r_rr_ptr      <= RR_A;
      r_out_clk     <= 1'b0;
      r_out_pulse   <= 1'b0;
      r_switch_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cur_div     <= w_cur_div_nxt;
      r_pend_div    <= w_pend_div_nxt;
      r_busy        <= w_busy_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_out_clk     <= w_out_clk_nxt;
      r_out_pulse   <= w_out_pulse_nxt;
      r_switch_done <= w_switch_done_nxt;
    end
  end

  assign ackA       = w_ack_a;
  assign ackB       = w_ack_b;
  assign outClk     = r_out_clk;
  assign outPulse   = r_out_pulse;
  assign curDiv     = r_cur_div;
  assign busy       = r_busy;
  assign switchDone = r_switch_done;

endmodule

// File: tb/tb_freq_divider_ctrl.sv
// Randomised bench for freq_divider_ctrl: a period-position model predicts every
// output each cycle, with a few hand-computed sequences pinning the model.
module tb_freq_divider_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DIV_W = 3;

  logic             inClk = 1'b0;
  logic             reset, run, reqA, reqB;
  logic [DIV_W-1:0] divA, divB;
  logic             ackA, ackB, outClk, outPulse, busy, switchDone;
  logic [DIV_W-1:0] curDiv;

  freq_divider_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .inClk(inClk), .reset(reset), .run(run),
    .reqA(reqA), .divA(divA), .ackA(ackA),
    .reqB(reqB), .divB(divB), .ackB(ackB),
    .outClk(outClk), .outPulse(outPulse), .curDiv(curDiv),
    .busy(busy), .switchDone(switchDone)
  );

  always #5 inClk = ~inClk;

  int checks = 0;
  int errors = 0;

  // Model: running flag, position inside the current output period, codes, arbitration.
  bit m_run, m_busy, m_rr, m_sd;
  int m_pos, m_d, m_pend;
  bit got_a, got_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_ack_a();
    return !reset && !m_busy && reqA && (!reqB || !m_rr);
  endfunction

  function automatic bit exp_ack_b();
    return !reset && !m_busy && reqB && !exp_ack_a();
  endfunction

  task automatic compare();
    int per;
    per = 2 << m_d;
    chk("ackA", 32'(ackA), 32'(exp_ack_a()));
    chk("ackB", 32'(ackB), 32'(exp_ack_b()));
    chk("curDiv", 32'(curDiv), 32'(m_d));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("switchDone", 32'(switchDone), 32'(m_sd));
    chk("outClk", 32'(outClk), 32'(m_run && (m_pos >= per / 2)));
    chk("outPulse", 32'(outPulse), 32'(m_run && m_pos == 0));
    got_a = ackA;
    got_b = ackB;
  endtask

  task automatic model_step();
    bit ga, gb;
    int per;
    if (reset) begin
      m_run = 0; m_busy = 0; m_rr = 0; m_sd = 0; m_pos = 0; m_d = 0; m_pend = 0;
      return;
    end
    ga = exp_ack_a();
    gb = exp_ack_b();
    per = 2 << m_d;
    m_sd = 0;
    if (!m_run) begin
      if (m_busy) begin m_d = m_pend; m_busy = 0; m_sd = 1; end
      m_run = run;
      m_pos = 0;
    end else if (m_pos == per - 1) begin
      if (m_busy) begin m_d = m_pend; m_busy = 0; m_sd = 1; end
      m_pos = 0;
      m_run = run;
    end else begin
      m_pos++;
    end
    if (ga) begin m_busy = 1; m_pend = int'(divA); m_rr = 1; end
    else if (gb) begin m_busy = 1; m_pend = int'(divB); m_rr = 0; end
  endtask

  task automatic half();
    @(negedge inClk);
    compare();
  endtask

  task automatic adv();
    @(posedge inClk);
    model_step();
    #1;
  endtask

  function automatic logic [DIV_W-1:0] pick();
    if ($urandom_range(0, 3) == 0) return DIV_W'($urandom_range(4, 7));
    return DIV_W'($urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b1; run = 1'b0;
    reqA = 1'b1; divA = 3'd1; reqB = 1'b1; divB = 3'd3;
    adv();
    // Reset held with both requests up: no grant.
    half(); chk("lit_rst_ackA", 32'(ackA), 0); chk("lit_rst_busy", 32'(busy), 0); adv();
    reset = 1'b0; run = 1'b1;
    half(); chk("lit_first_ackA", 32'(ackA), 1); chk("lit_first_ackB", 32'(ackB), 0); adv();
    reqA = 1'b0;
    half(); chk("lit_run0_pulse", 32'(outPulse), 1); chk("lit_run0_clk", 32'(outClk), 0);
    chk("lit_run0_busy", 32'(busy), 1); chk("lit_run0_ackB", 32'(ackB), 0); adv();
    half(); chk("lit_run1_clk", 32'(outClk), 1); chk("lit_run1_pulse", 32'(outPulse), 0); adv();
    half(); chk("lit_applyA_div", 32'(curDiv), 1); chk("lit_applyA_sd", 32'(switchDone), 1);
    chk("lit_applyA_pulse", 32'(outPulse), 1); chk("lit_applyA_ackB", 32'(ackB), 1); adv();
    reqB = 1'b0;
    half(); chk("lit_B_busy", 32'(busy), 1); chk("lit_B_clk", 32'(outClk), 0); adv();
    half(); chk("lit_d1_c2_clk", 32'(outClk), 1); adv();
    half(); chk("lit_d1_c3_clk", 32'(outClk), 1); adv();
    half(); chk("lit_applyB_div", 32'(curDiv), 3); chk("lit_applyB_sd", 32'(switchDone), 1);
    chk("lit_applyB_clk", 32'(outClk), 0);
    // Both request again: pointer now favours A.
    reqA = 1'b1; divA = 3'd2; reqB = 1'b1; divB = 3'd5;
    #1; chk("lit_rr_ackA", 32'(ackA), 1); chk("lit_rr_ackB", 32'(ackB), 0);
    adv();
    reqA = 1'b0;

    for (int i = 0; i < 6000; i++) begin
      half();
      adv();
      if (got_a) reqA = 1'b0;
      else if (!reqA && $urandom_range(0, 15) == 0) begin reqA = 1'b1; divA = pick(); end
      if (got_b) reqB = 1'b0;
      else if (!reqB && $urandom_range(0, 15) == 0) begin reqB = 1'b1; divB = pick(); end
      if (run) run = ($urandom_range(0, 99) != 0);
      else run = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 499) == 0);
    end

    // Drain to STOP with nothing pending.
    reset = 1'b0; run = 1'b0; reqA = 1'b0; reqB = 1'b0;
    begin
      int n;
      n = 0;
      while ((m_run || m_busy) && n < 1000) begin half(); adv(); n++; end
      chk("stop_wait_timeout", 32'(n < 1000), 1);
    end
    reqB = 1'b1; divB = 3'd7;
    half(); chk("lit_stop_ackB", 32'(ackB), 1); chk("lit_stop_clk", 32'(outClk), 0); adv();
    reqB = 1'b0;
    half(); chk("lit_stop_busy", 32'(busy), 1); adv();
    half(); chk("lit_stop_div", 32'(curDiv), 7); chk("lit_stop_sd", 32'(switchDone), 1);
    chk("lit_stop_busy0", 32'(busy), 0); chk("lit_stop_clk2", 32'(outClk), 0); adv();

    // Reset while a capture is pending; held request re-granted after reset.
    run = 1'b1; reqA = 1'b1; divA = 3'd6;
    half(); chk("lit_pre_ackA", 32'(ackA), 1); adv();
    divA = 3'd2; reset = 1'b1;
    half(); chk("lit_rstbusy_busy", 32'(busy), 1); chk("lit_rstbusy_ackA", 32'(ackA), 0); adv();
    reset = 1'b0;
    half(); chk("lit_post_busy", 32'(busy), 0); chk("lit_post_div", 32'(curDiv), 0);
    chk("lit_post_sd", 32'(switchDone), 0); chk("lit_post_clk", 32'(outClk), 0);
    chk("lit_post_ackA", 32'(ackA), 1); adv();
    reqA = 1'b0;
    for (int i = 0; i < 20; i++) begin half(); adv(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
